hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage core. It sits in front of the operand-forwarding logic and drives the stall, bubble and flush enables of the PC and the IF/ID, ID/EX and EX/MEM registers. It covers three cases:
- load-use hazards, which forwarding cannot resolve;
- taken-branch redirects, including instruction-memory read latency;
- data-memory back-pressure.

## Interface
Parameters:
- FLUSH_CYCLES, default 1: extra cycles of fetch discard after a redirect, matching the instruction-memory read latency. Legal range 0..7.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- control_ex  in  control_t  control word of the instruction in EX. Uses write_back_id and mem_read.
- rs_1  in  5  source register 1 of the instruction in ID.
- rs_2  in  5  source register 2 of the instruction in ID.
- branch_taken  in  1  the branch/jump in EX resolved taken this cycle.
- mem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- pc_write_en  out  1  PC register load enable.
- if_id_write_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_flush  out  1  ID/EX loads a bubble (all-zero control_t).
- ex_mem_write_en  out  1  EX/MEM register load enable.
- stall_cycles  out  32  load-use stall cycle counter (macro-dependent).
- flush_cycles  out  32  redirect/discard cycle counter (macro-dependent).

## Operation
- **FSM states:**
  - RUN: normal flow.
  - FLUSH: discarding stale fetches after a redirect. A 3-bit down-counter `cnt` tracks the remaining discard cycles.
- **Load-use detect** (`lu`): control_ex.mem_read == 1 and control_ex.write_back_id != 0 and (write_back_id == rs_1 or write_back_id == rs_2).
  - Destination x0 never creates a hazard.
- **Per-cycle priority:** rst > mem_busy > redirect (branch_taken in RUN) > lu in RUN > FLUSH discard > normal.
- **rst:**
  - pc_write_en = 0, if_id_write_en = 0, ex_mem_write_en = 0.
  - if_id_flush = 1, id_ex_flush = 1.
  - Next state RUN, cnt = 0.
- **mem_busy:**
  - All write enables are 0; both flushes are 0, so every stage freezes.
  - State and cnt hold. A branch_taken presented during mem_busy is ignored; the frozen EX stage re-presents it once busy drops.
- **Redirect** (RUN and branch_taken):
  - pc_write_en = 1, so the PC loads the target.
  - if_id_flush = 1, id_ex_flush = 1, ex_mem_write_en = 1.
  - If FLUSH_CYCLES > 0: next state FLUSH with cnt = FLUSH_CYCLES. Otherwise stay in RUN.
  - A simultaneous lu is dropped; the ID instruction is on the wrong path.
- **Load-use stall** (RUN and lu):
  - pc_write_en = 0, if_id_write_en = 0, id_ex_flush = 1, ex_mem_write_en = 1.
  - Stays in RUN. The load advances to MEM, so lu clears the next cycle and forwarding supplies the loaded value from WB.
- **FLUSH** (not mem_busy):
  - pc_write_en = 1, if_id_flush = 1, id_ex_flush = 1, ex_mem_write_en = 1.
  - cnt decrements. When cnt == 1, the next state is RUN.
  - branch_taken and lu are ignored in FLUSH, since ID and EX hold only bubbles.
- **Normal:** all write enables 1, flushes 0.

## Timing
- All hazard outputs are combinational (Mealy) from state, cnt and the current inputs. Zero-cycle reaction; no registered outputs.
- A load-use costs exactly 1 bubble.
- A taken branch costs 2 + FLUSH_CYCLES cycles of lost issue.
- mem_busy for N cycles freezes the pipeline for exactly N cycles, with no lost instructions.
- State and cnt are registered. Their reset values are RUN and 0.

## Configuration
- **HAZARD_PERF_CNT_EN defined:**
  - stall_cycles increments on each cycle where the load-use stall is applied.
  - flush_cycles increments on each redirect cycle and each FLUSH discard cycle.
  - Neither counter increments while mem_busy or rst is asserted.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- **Not defined:** both outputs are tied to 0 and no counter flops are generated.

## Structure
- common_pkg gains:
  - hazard_state_t enum {HZ_RUN, HZ_FLUSH};
  - constant BUBBLE_CONTROL (control_t, all zero), shared with the ID/EX register flush path.
- The FSM and cnt live in the top module.
- The two saturating counters come from one sub-module, perf_counter (parameter WIDTH = 32; ports clk, rst, inc, count), instantiated twice under HAZARD_PERF_CNT_EN.

## Test plan
- **Load-use:** lw x5 in EX (mem_read = 1, write_back_id = 5), rs_1 = 5 in ID → one cycle of pc_write_en = 0, if_id_write_en = 0, id_ex_flush = 1; the next cycle returns to normal; stall_cycles = 1.
- **x0 and non-matching sources:** write_back_id = 0 with rs_1 = 0, and write_back_id = 7 with rs_1 = 3, rs_2 = 4 → no stall; all enables 1.
- **Redirect with FLUSH_CYCLES = 2:** branch_taken for 1 cycle with lu also true → redirect outputs (pc_write_en = 1, both flushes 1), then 2 FLUSH cycles, then RUN; stall_cycles unchanged; flush_cycles = 3.
- **Back-pressure:** mem_busy high for 4 cycles during FLUSH with cnt = 2 → all enables 0 for 4 cycles, cnt held at 2; FLUSH completes afterwards.
- **Mid-flush reset:** rst asserted while in FLUSH → outputs take reset values in that cycle; the next cycle is RUN with cnt = 0; counters read 0.
- **Saturation (macro on):** force stall_cycles to 0xFFFFFFFE, apply 3 load-use stalls → reads 0xFFFFFFFF. With the macro off, both counters read 0 throughout.

Source files
------------

// File: rtl/common_pkg.sv
// Shared core types: control word, hazard FSM states and the ID/EX bubble constant.
package common_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [4:0] write_back_id;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       jump;
    } control_t;

    // ID/EX flush loads this: no writes, no memory access, no redirect.
    localparam control_t BUBBLE_CONTROL = '0;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_unit_perf_counter.sv
// Saturating event counter used for the hazard performance statistics.
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (inc && (r_count != {WIDTH{1'b1}}))
            r_count <= r_count + WIDTH'(1);
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Stall/bubble/flush control for the 5-stage pipeline: load-use, redirect discard, memory back-pressure.
// Optional cycle counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit
    import common_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  control_t    control_ex,
    input  logic [4:0]  rs_1,
    input  logic [4:0]  rs_2,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_write_en,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
);

    localparam logic [2:0] LP_FLUSH = 3'(FLUSH_CYCLES);

    hazard_state_t r_state, w_next_state;
    logic [2:0]    r_cnt, w_next_cnt;
    logic          w_lu;
    logic          w_unused_ctrl;

    assign w_lu = control_ex.mem_read && (control_ex.write_back_id != 5'd0) &&
                  ((control_ex.write_back_id == rs_1) || (control_ex.write_back_id == rs_2));

    // Only mem_read and write_back_id matter here.
    assign w_unused_ctrl = ^{control_ex.reg_write, control_ex.mem_write, control_ex.mem_to_reg,
                             control_ex.alu_src, control_ex.alu_op, control_ex.branch, control_ex.jump};

    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b1;
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        if (rst) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            w_next_state    = HZ_RUN;
            w_next_cnt      = 3'd0;
        end else if (mem_busy) begin
            // Freeze everything; a branch in EX is re-presented once busy drops.
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
        end else if ((r_state == HZ_RUN) && branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (LP_FLUSH != 3'd0) begin
                w_next_state = HZ_FLUSH;
                w_next_cnt   = LP_FLUSH;
            end
        end else if ((r_state == HZ_RUN) && w_lu) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end else if (r_state == HZ_FLUSH) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_next_cnt  = r_cnt - 3'd1;
            if (r_cnt == 3'd1)
                w_next_state = HZ_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HZ_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic w_stall_inc, w_flush_inc;

    assign w_stall_inc = !rst && !mem_busy && (r_state == HZ_RUN) && !branch_taken && w_lu;
    assign w_flush_inc = !rst && !mem_busy &&
                         (((r_state == HZ_RUN) && branch_taken) || (r_state == HZ_FLUSH));

    perf_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cycles)
    );

    perf_counter #(.WIDTH(32)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cycles)
    );
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (FLUSH_CYCLES = 2) with a queue scoreboard of expected outputs.
module tb_hazard_unit;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    control_t    control_ex;
    logic [4:0]  rs_1, rs_2;
    logic        branch_taken, mem_busy;
    logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en;
    logic [31:0] stall_cycles, flush_cycles;

    hazard_unit #(.FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .control_ex      (control_ex),
        .rs_1            (rs_1),
        .rs_2            (rs_2),
        .branch_taken    (branch_taken),
        .mem_busy        (mem_busy),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write_en (ex_mem_write_en),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [4:0]    outs;   // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we}
        hazard_state_t st;
        logic [2:0]    cnt;
        logic [31:0]   sc;
        logic [31:0]   fc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_sc = 0;
    logic [31:0] m_fc = 0;

    localparam logic [4:0] O_NORM  = 5'b11001;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_REDIR = 5'b11111;
    localparam logic [4:0] O_RST   = 5'b00110;
    localparam logic [4:0] O_BUSY  = 5'b00000;

    function automatic logic [31:0] visible(input logic [31:0] m);
`ifdef HAZARD_PERF_CNT_EN
        return m;
`else
        return (m & 32'd0);
`endif
    endfunction

    task automatic apply(input logic r, input logic bt, input logic mb, input logic mr,
                         input logic [4:0] wb, input logic [4:0] s1, input logic [4:0] s2);
        @(posedge clk);
        #1;
        rst                      = r;
        branch_taken             = bt;
        mem_busy                 = mb;
        control_ex               = BUBBLE_CONTROL;
        control_ex.mem_read      = mr;
        control_ex.write_back_id = wb;
        control_ex.reg_write     = (wb != 5'd0);
        rs_1                     = s1;
        rs_2                     = s2;
    endtask

    task automatic step(input string tag, input logic r, input logic bt, input logic mb,
                        input logic mr, input logic [4:0] wb, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] outs, input hazard_state_t st,
                        input logic [2:0] cnt, input logic si, input logic fi);
        exp_t e, g;
        logic [4:0] obs;
        apply(r, bt, mb, mr, wb, s1, s2);
        e.tag = tag; e.outs = outs; e.st = st; e.cnt = cnt;
        e.sc = visible(m_sc); e.fc = visible(m_fc);
        q.push_back(e);
        @(negedge clk);
        g = q.pop_front();
        obs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, ex_mem_write_en};
        checks++;
        assert (obs === g.outs) else begin
            errors++; $error("FAIL %s.outs got=%b want=%b", g.tag, obs, g.outs);
        end
        checks++;
        assert (dut.r_state === g.st) else begin
            errors++; $error("FAIL %s.state got=%0d want=%0d", g.tag, dut.r_state, g.st);
        end
        checks++;
        assert (dut.r_cnt === g.cnt) else begin
            errors++; $error("FAIL %s.cnt got=%0d want=%0d", g.tag, dut.r_cnt, g.cnt);
        end
        checks++;
        assert (stall_cycles === g.sc) else begin
            errors++; $error("FAIL %s.stall_cycles got=%h want=%h", g.tag, stall_cycles, g.sc);
        end
        checks++;
        assert (flush_cycles === g.fc) else begin
            errors++; $error("FAIL %s.flush_cycles got=%h want=%h", g.tag, flush_cycles, g.fc);
        end
        // Model update for the edge that ends this cycle.
        if (r) begin
            m_sc = 0; m_fc = 0;
        end else begin
            if (si && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (fi && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end
    endtask

    initial begin
        apply(1, 0, 0, 0, 0, 0, 0);
        //   tag        rst bt mb mr wb  rs1 rs2 outs     state     cnt si fi
        step("reset",     1, 0, 0, 0, 0,  0,  0, O_RST,   HZ_RUN,   0, 0, 0);
        step("normal",    0, 0, 0, 0, 0,  0,  0, O_NORM,  HZ_RUN,   0, 0, 0);
        step("lu_rs1",    0, 0, 0, 1, 5,  5,  9, O_STALL, HZ_RUN,   0, 1, 0);
        step("lu_clear",  0, 0, 0, 0, 5,  5,  9, O_NORM,  HZ_RUN,   0, 0, 0);
        step("x0",        0, 0, 0, 1, 0,  0,  0, O_NORM,  HZ_RUN,   0, 0, 0);
        step("nomatch",   0, 0, 0, 1, 7,  3,  4, O_NORM,  HZ_RUN,   0, 0, 0);
        step("lu_rs2",    0, 0, 0, 1, 7,  1,  7, O_STALL, HZ_RUN,   0, 1, 0);
        step("busy_lu",   0, 0, 1, 1, 7,  7,  0, O_BUSY,  HZ_RUN,   0, 0, 0);
        step("busy_br",   0, 1, 1, 0, 0,  0,  0, O_BUSY,  HZ_RUN,   0, 0, 0);
        step("redir_lu",  0, 1, 0, 1, 5,  5,  0, O_REDIR, HZ_RUN,   0, 0, 1);
        step("flush2",    0, 1, 0, 1, 5,  5,  0, O_REDIR, HZ_FLUSH, 2, 0, 1);
        step("flush1",    0, 0, 0, 1, 5,  5,  0, O_REDIR, HZ_FLUSH, 1, 0, 1);
        step("post_fl",   0, 0, 0, 0, 0,  0,  0, O_NORM,  HZ_RUN,   0, 0, 0);
        step("redir_b",   0, 1, 0, 0, 0,  0,  0, O_REDIR, HZ_RUN,   0, 0, 1);
        for (int i = 0; i < 4; i++)
            step("bp_busy", 0, 1, 1, 1, 3,  3,  0, O_BUSY,  HZ_FLUSH, 2, 0, 0);
        step("bp_fl2",    0, 0, 0, 0, 0,  0,  0, O_REDIR, HZ_FLUSH, 2, 0, 1);
        step("bp_fl1",    0, 0, 0, 0, 0,  0,  0, O_REDIR, HZ_FLUSH, 1, 0, 1);
        step("bp_done",   0, 0, 0, 0, 0,  0,  0, O_NORM,  HZ_RUN,   0, 0, 0);
        step("redir_c",   0, 1, 0, 0, 0,  0,  0, O_REDIR, HZ_RUN,   0, 0, 1);
        step("rst_fl",    1, 0, 0, 0, 0,  0,  0, O_RST,   HZ_FLUSH, 2, 0, 0);
        step("after_rst", 0, 0, 0, 0, 0,  0,  0, O_NORM,  HZ_RUN,   0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        force dut.u_stall_cnt.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.r_count;
        m_sc = 32'hFFFF_FFFE;
`endif
        for (int i = 0; i < 3; i++)
            step("sat_lu",  0, 0, 0, 1, 9,  9,  9, O_STALL, HZ_RUN,   0, 1, 0);
        step("sat_end",   0, 0, 0, 0, 0,  0,  0, O_NORM,  HZ_RUN,   0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
